pipe_stall_ctrl: RTL
====================

# pipe_stall_ctrl

Central stall and sequencing controller for the 5-stage integer pipeline. It detects load-use hazards that the register-file bypass network cannot resolve, because EX does not yet have load data. It also sequences the multi-cycle divider held in EX and drives the per-stage `stall` vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sits beside the ID stage and observes the same EX write-back fields carried on the 38-bit EX-to-ID forwarding bus.

## Interface
- `DIV_TIMEOUT`, default 40: maximum DIV_ON cycles before the watchdog releases the pipeline.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  exception/redirect flush; overrides all stalls.
- `id_re1`, `id_re2`  in  1 each  ID read-port enables.
- `id_raddr1`, `id_raddr2`  in  5 each  ID read addresses.
- `ex_to_id_bus`  in  38  {we[37], waddr[36:32], result[31:0]} from EX; only bits 37:32 are used.
- `ex_is_load`  in  1  EX holds a load instruction.
- `ex_div_req`  in  1  EX holds div/divu.
- `ex_div_signed`  in  1  1 = div, 0 = divu.
- `div_ready`  in  1  divider result valid; single-cycle pulse.
- `stall`  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB. 1 = hold that stage's register.
- `div_start`  out  1  registered one-cycle start pulse to the divider.
- `div_signed`  out  1  registered copy of `ex_div_signed`, captured with `div_start`.
- `div_annul`  out  1  registered one-cycle abort pulse to the divider.
- `div_timeout`  out  1  sticky watchdog error flag.
- `stall_cycles`  out  32  count of cycles with `stall[0]`=1; wraps.

## Operation
- Stall convention: a stage with `stall[i]`=1 and `stall[i+1]`=0 inserts a bubble downstream. Only 6'b000000, 6'b000111 and 6'b001111 are ever driven.
- FSM states: IDLE, DIV_ON, DIV_END. Encoding is free; the state is registered.
- IDLE:
  - `ex_div_req`=1 and `flush`=0: drive `stall`=6'b001111 combinationally, go to DIV_ON, load `div_start`=1 and `div_signed`=`ex_div_signed`, clear `cnt`.
- DIV_ON:
  - `stall`=6'b001111 every cycle, including the cycle `div_ready` is high.
  - `cnt` (6-bit) increments each cycle.
  - `div_ready`=1: go to DIV_END.
  - `cnt`==DIV_TIMEOUT-1 with no `div_ready`: set `div_timeout`, go to DIV_END.
- DIV_END:
  - Division stall is released for one cycle so the result leaves EX.
  - `ex_div_req` is ignored here, because it is still the same instruction.
  - Always go to IDLE.
- Load-use hazard:
  - Condition: `ex_is_load` & we & waddr≠0 & ((`id_re1` & `id_raddr1`==waddr) | (`id_re2` & `id_raddr2`==waddr)).
  - Response: `stall`=6'b000111 (PC/IF/ID hold, bubble into EX), combinational, exactly one cycle per load.
- Priority:
  1. `flush`
  2. Division stall (IDLE request or DIV_ON)
  3. Load-use
  4. None
- While a division stall is asserted, the load-use condition is masked; EX is frozen, so it is re-evaluated after release.
- `flush` effects:
  - `stall`=0 in the same cycle; the next state is IDLE.
  - `div_start` is not issued.
  - If the current state is DIV_ON, `div_annul` pulses in the next cycle.
  - A `div_ready` coincident with `flush` is discarded.
- `stall_cycles` increments at each edge where `stall[0]`=1; it wraps 0xFFFFFFFF→0.

## Timing
- Reset values: state IDLE, `stall`=0, `div_start`=0, `div_signed`=0, `div_annul`=0, `div_timeout`=0, `cnt`=0, `stall_cycles`=0.
- Division sequence, with `ex_div_req` first high at cycle T:
  - `stall` high from T.
  - `div_start` high at T+1 only.
  - `div_ready` at cycle R ≥ T+1 gives `stall`=0 at R+1 (DIV_END).
  - Total freeze of EX = R−T+1 cycles.
- A back-to-back division entering EX at R+2 starts a fresh sequence from IDLE.
- Load-use: exactly 1 bubble cycle; no registered state.
- `div_timeout` clears only on `rst`.
- `rst` mid-division: all state clears immediately; no `div_annul` is issued.

## Test plan
- Load r5 in EX (we=1, waddr=5), ID `id_re1`=1, `id_raddr1`=5 → `stall`=000111 for 1 cycle, then 0. Repeat with waddr=0 → no stall.
- Division at T, `div_ready` at T+33 → `stall`=001111 for T..T+33, `div_start` only at T+1, `stall`=0 at T+34, state IDLE at T+35, `stall_cycles`=34.
- Division plus a simultaneous load-use condition → `stall`=001111 (division wins); after release, the load-use bubble is not double-counted.
- `flush` at T+5 of DIV_ON → `stall`=0 at T+5, `div_annul` at T+6, IDLE; a later `div_ready` pulse is ignored.
- `div_ready` never arrives, DIV_TIMEOUT=40 → `div_timeout`=1 after 40 DIV_ON cycles, pipeline released, flag stays high until `rst`.
- Assert `rst` during DIV_ON → all outputs read 0 asynchronously, with no `div_start` or `div_annul` pulse.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Central stall/sequencing controller for the 5-stage integer pipeline.
//   Detects load-use hazards the bypass network cannot cover, sequences the
//   multi-cycle divider held in EX and drives the per-stage stall vector.
//
// Ports
//   clk, rst          pipeline clock (rising edge), async active-high reset
//   flush             exception/redirect flush, overrides every stall
//   id_re1/2          ID read-port enables
//   id_raddr1/2       ID read addresses
//   ex_to_id_bus      {we, waddr[4:0], result[31:0]} from EX (result unused)
//   ex_is_load        EX holds a load
//   ex_div_req        EX holds div/divu
//   ex_div_signed     1 = div, 0 = divu
//   div_ready         divider result valid pulse
//   stall[5:0]        {WB, MEM, EX, ID, IF, PC} hold enables
//   div_start         one-cycle start pulse to the divider
//   div_signed        signedness captured with div_start
//   div_annul         one-cycle abort pulse to the divider
//   div_timeout       sticky watchdog error flag
//   stall_cycles      count of cycles with stall[0] set, wraps
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no division in flight; a div request stalls and launches one
// DIV_ON  | divider busy, EX and everything upstream frozen
// DIV_END | one-cycle release so the quotient leaves EX; request ignored

module pipe_stall_ctrl #(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        id_re1,
  input  logic        id_re2,
  input  logic [4:0]  id_raddr1,
  input  logic [4:0]  id_raddr2,
  input  logic [37:0] ex_to_id_bus,
  input  logic        ex_is_load,
  input  logic        ex_div_req,
  input  logic        ex_div_signed,
  input  logic        div_ready,
  output logic [5:0]  stall,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic        div_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_ON  = 2'd1,
    DIV_END = 2'd2
  } state_t;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LU   = 6'b000111;
  localparam logic [5:0] STALL_DIV  = 6'b001111;
  localparam logic [5:0] CNT_LAST   = 6'(DIV_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        div_start_q, div_start_d;
  logic        div_signed_q, div_signed_d;
  logic        div_annul_q, div_annul_d;
  logic        div_timeout_q, div_timeout_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic        unused_result;
  logic        hit1, hit2;
  logic        load_use;
  logic        div_stall;
  logic [5:0]  stall_c;

  assign ex_we         = ex_to_id_bus[37];
  assign ex_waddr      = ex_to_id_bus[36:32];
  assign unused_result = ^ex_to_id_bus[31:0];

  // r0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign hit1     = id_re1 && (id_raddr1 == ex_waddr);
  assign hit2     = id_re2 && (id_raddr2 == ex_waddr);
  assign load_use = ex_is_load && ex_we && (ex_waddr != 5'd0) && (hit1 || hit2);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_start_d   = 1'b0;
    div_signed_d  = div_signed_q;
    div_annul_d   = 1'b0;
    div_timeout_d = div_timeout_q;
    div_stall     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_div_req) begin
          div_stall    = 1'b1;
          state_d      = DIV_ON;
          div_start_d  = 1'b1;
          div_signed_d = ex_div_signed;
          cnt_d        = 6'd0;
        end
      end
      DIV_ON: begin
        div_stall = 1'b1;
        cnt_d     = cnt_q + 6'd1;
        if (div_ready) begin
          state_d = DIV_END;
        end else if (cnt_q == CNT_LAST) begin
          div_timeout_d = 1'b1;
          state_d       = DIV_END;
        end
      end
      DIV_END: begin
        // Same div instruction is still in EX this cycle; let it drain.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush kills everything in flight: no start, no timeout, and an abort
    // to the divider if it was actually running.
    if (flush) begin
      state_d       = IDLE;
      cnt_d         = cnt_q;
      div_start_d   = 1'b0;
      div_signed_d  = div_signed_q;
      div_timeout_d = div_timeout_q;
      div_annul_d   = (state_q == DIV_ON);
    end
  end

  // Division stall masks the load-use check: EX is frozen, so the hazard is
  // re-evaluated once the divider releases the pipe.
  always_comb begin
    stall_c = STALL_NONE;
    if (flush) begin
      stall_c = STALL_NONE;
    end else if (div_stall) begin
      stall_c = STALL_DIV;
    end else if (load_use) begin
      stall_c = STALL_LU;
    end
  end

  // Reset forces the stall vector low at once, even if a div request is
  // still presented on the inputs.
  assign stall = rst ? STALL_NONE : stall_c;

  assign stall_cycles_d = stall_cycles_q + {31'd0, stall[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 6'd0;
      div_start_q    <= 1'b0;
      div_signed_q   <= 1'b0;
      div_annul_q    <= 1'b0;
      div_timeout_q  <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      div_start_q    <= div_start_d;
      div_signed_q   <= div_signed_d;
      div_annul_q    <= div_annul_d;
      div_timeout_q  <= div_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign div_start    = div_start_q;
  assign div_signed   = div_signed_q;
  assign div_annul    = div_annul_q;
  assign div_timeout  = div_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule
